// File: rtl/dot4_pkg.sv
// Shared types and constants for the dot-product accumulator.
// The parameter check is evaluated at elaboration by the top module.
package dot4_pkg;

   localparam int unsigned PROD_W = 8;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } acc_state_e;

   function automatic bit params_ok(input int unsigned acc_w, input int unsigned n_terms);
      return (acc_w >= PROD_W) && (n_terms >= 1) && (n_terms <= 15);
   endfunction

endpackage

// File: rtl/dot4_accumulator_if.sv
// Product input and result output handshakes of the dot-product accumulator.
interface dot4_accumulator_if
   import dot4_pkg::*;
#(
   parameter int unsigned ACC_W = 12
) ();

   logic              prod_valid;
   logic              prod_ready;
   logic [PROD_W-1:0] prod_data;
   logic              prod_cout;
   logic              res_valid;
   logic              res_ready;
   logic [ACC_W-1:0]  res_data;
   logic              res_ovf;

   modport master (
      output prod_valid, prod_data, prod_cout, res_ready,
      input  prod_ready, res_valid, res_data, res_ovf
   );

   modport slave (
      input  prod_valid, prod_data, prod_cout, res_ready,
      output prod_ready, res_valid, res_data, res_ovf
   );

endinterface

// File: rtl/dot4_acc_fsm.sv
// Group sequencer: tracks ACC/DONE and the term counter, and emits
// load/add strobes for the datapath on each accepted product.
module dot4_acc_fsm
   import dot4_pkg::*;
#(
   parameter int unsigned N_TERMS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic prod_valid,
   input  logic res_ready,
   output logic prod_ready,
   output logic load,
   output logic add,
   output logic res_valid
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

   acc_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // clear overrides everything, including a result handshake in DONE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = ST_ACC;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_ACC: begin
               if (accept) begin
                  if (cnt_q == LAST_CNT) begin
                     state_d = ST_DONE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_DONE: begin
               if (res_ready) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
         endcase
      end
   end

   always_comb begin
      prod_ready = 1'b0;
      accept     = 1'b0;
      load       = 1'b0;
      add        = 1'b0;
      prod_ready = (state_q == ST_ACC) && !clear && rst_n;
      accept     = prod_valid && prod_ready;
      load       = accept && (cnt_q == '0);
      add        = accept && (cnt_q != '0);
   end

   assign res_valid = (state_q == ST_DONE);

endmodule

// File: rtl/dot4_accumulator.sv
// Sums N_TERMS unsigned products into one result with a sticky per-group
// overflow flag; result is held on a valid/ready port until taken.
module dot4_accumulator
   import dot4_pkg::*;
#(
   parameter int unsigned N_TERMS = 4,
   parameter int unsigned ACC_W   = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   dot4_accumulator_if.slave  bus
);

   localparam int unsigned SUM_W = ACC_W + 1;

   if (!params_ok(ACC_W, N_TERMS)) begin : g_bad_params
      $error("dot4_accumulator: need ACC_W >= 8 and 1 <= N_TERMS <= 15");
   end

   logic             load, add, res_valid;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [SUM_W-1:0] sum;

   dot4_acc_fsm #(
      .N_TERMS (N_TERMS)
   ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .prod_valid (bus.prod_valid),
      .res_ready  (bus.res_ready),
      .prod_ready (bus.prod_ready),
      .load       (load),
      .add        (add),
      .res_valid  (res_valid)
   );

   // Extra MSB of the sum is the wrap carry feeding the sticky flag
   assign sum = {1'b0, acc_q} + SUM_W'(bus.prod_data);

   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (clear) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (load) begin
         acc_d = ACC_W'(bus.prod_data);
         ovf_d = bus.prod_cout;
      end else if (add) begin
         acc_d = sum[ACC_W-1:0];
         ovf_d = ovf_q | sum[ACC_W] | bus.prod_cout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.res_valid = res_valid;
   assign bus.res_data  = acc_q;
   assign bus.res_ovf   = ovf_q;

endmodule
